lab_readout_scheduler: RTL and testbench
========================================

Name: lab_readout_scheduler

Overview:
Sequences digitization and readout of the four LAB hold buffers on clk33_i. It sits between the buffer handler, which raises per-buffer digitize requests after a HOLD, and LAB_TOPv2, which digitizes and reports a per-LAB done mask. It grants one buffer at a time in round-robin order and holds digitize for a guaranteed minimum time. It then issues the clear/release pulse back to the buffer handler, tags each completed readout with an event number, and recovers from a LAB that never finishes via a timeout.

Parameters:
NUM_BUF, 4, number of hold buffers (index width fixed at 2 bits; only 4 supported)
MIN_DIG_CYCLES, 4, minimum clk33_i cycles digitize_o stays high (≥100 ns)
TIMEOUT_CYCLES, 65535, max cycles in WAIT_DONE before forced completion (16-bit counter)

Ports:
clk33_i  in  1  33 MHz system clock
rst_i  in  1  synchronous active-high reset
digitize_req_i  in  4  per-buffer request level from buffer handler; rising edge = new request
lab_done_i  in  4  per-LAB done mask from LAB_TOPv2
lab_mask_i  in  4  LAB enable; disabled LABs count as done
digitize_o  out  4  one-hot digitize command to LAB_TOPv2 (bit = buffer index)
clear_o  out  1  one-cycle release pulse to buffer handler
clear_buffer_o  out  2  buffer index released; valid with clear_o
event_valid_o  out  1  one-cycle pulse, coincident with clear_o
event_count_o  out  32  events completed since reset, including the one being pulsed
event_buf_o  out  2  buffer of last completed event
busy_o  out  1  high whenever state != IDLE or any request pending
timeout_o  out  1  sticky: some readout timed out
req_err_o  out  1  sticky: request edge on a buffer already pending or in service

Behaviour:
- Reset, which wins over everything:
  - All outputs go to 0.
  - pending[3:0]=0, the registered request copy =0, and the round-robin pointer last=3, so buffer 0 wins first.
  - Reset mid-operation aborts with no clear_o pulse.
- Request capture:
  - edge[n] = digitize_req_i[n] & ~req_q[n].
  - The edge sets pending[n] on the next clock edge.
  - If pending[n] is already set, or n is in service, set req_err_o and drop the request.
  - Simultaneous edges on several buffers all set pending in the same cycle.
- Arbitration, only in IDLE: grant the first pending index scanning last+1, last+2, … modulo 4.
  - On grant: clear pending[sel], set last=sel, go to ASSERT.
- FSM states: IDLE, ASSERT, WAIT_DONE, CLEAR, GAP.
  - IDLE: grant if any pending, else stay.
  - ASSERT:
    - digitize_o = 1<<sel for exactly MIN_DIG_CYCLES cycles; the counter loads 1 on entry.
    - Ignore lab_done_i.
    - Go to WAIT_DONE.
  - WAIT_DONE:
    - digitize_o stays high.
    - Exit to CLEAR when (lab_done_i | ~lab_mask_i)==4'hF.
    - Also exit to CLEAR, setting timeout_o, when the timeout counter reaches TIMEOUT_CYCLES−1.
    - With lab_mask_i=0, WAIT_DONE lasts exactly 1 cycle.
  - CLEAR, 1 cycle:
    - digitize_o=0, clear_o=1, clear_buffer_o=sel, event_valid_o=1.
    - event_count_o increments (wraps 0xFFFFFFFF→0); event_buf_o=sel.
  - GAP, 1 cycle, all strobes low: guarantees LAB_TOPv2 sees digitize low before the next grant. Then IDLE.
- Latency, idle scheduler:
  - Request edge sampled at edge k → pending at k+1.
  - Grant at k+1, with digitize_o high from k+2.
  - Minimum per-event cycle: 1 + MIN_DIG_CYCLES + 1 + 1 + 1 = 8 cycles.
- A request arriving during service is queued and served after GAP, in round-robin order from the buffer just served.
- clear_buffer_o and event_buf_o hold their last value outside CLEAR; event_count_o holds between events.

Test Plan:
- Single request, lab_mask_i=F: edge on req[2] at cycle 10 → digitize_o=4'b0100 at cycle 12. Hold lab_done_i=F from cycle 20 → clear_o, event_valid_o, clear_buffer_o=2 at cycle 21; event_count_o=1; GAP then IDLE, busy_o low at cycle 23.
- Simultaneous edges on req[3:0]=F after reset → service order 0,1,2,3 → four clear_o pulses, event_count_o=4, event_buf_o=3.
- Round-robin: serve buffer 1, then raise edges on req 0 and 2 during its WAIT_DONE → next grant 2, then 0.
- Minimum width: lab_done_i stuck at F and lab_mask_i=F → digitize_o high exactly 5 cycles (4 ASSERT + 1 WAIT_DONE).
- Timeout with TIMEOUT_CYCLES=16, lab_done_i=0, lab_mask_i=F → clear_o fires after 16 WAIT_DONE cycles; timeout_o=1 and stays 1 until rst_i.
- Second edge on req[1] while buffer 1 pending → req_err_o=1, buffer 1 served once. Assert rst_i during WAIT_DONE → next cycle all outputs 0, no clear_o, event_count_o=0.

Source files
------------

// File: rtl/lab_readout_scheduler.sv
// Round-robin digitize/readout sequencer for the four LAB hold buffers.
// Grants one buffer at a time, enforces a minimum digitize width, and times out stuck LABs.
module lab_readout_scheduler #(
  parameter int unsigned NUM_BUF        = 4,
  parameter int unsigned MIN_DIG_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               clk33_i,
  input  logic               rst_i,
  input  logic [NUM_BUF-1:0] digitize_req_i,
  input  logic [NUM_BUF-1:0] lab_done_i,
  input  logic [NUM_BUF-1:0] lab_mask_i,
  output logic [NUM_BUF-1:0] digitize_o,
  output logic               clear_o,
  output logic [1:0]         clear_buffer_o,
  output logic               event_valid_o,
  output logic [31:0]        event_count_o,
  output logic [1:0]         event_buf_o,
  output logic               busy_o,
  output logic               timeout_o,
  output logic               req_err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StAssert,
    StWaitDone,
    StClear,
    StGap
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_BUF-1:0] req_q, pending_q, pending_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         last_q, last_d;
  logic [15:0]        dig_cnt_q, dig_cnt_d;
  logic [15:0]        to_cnt_q, to_cnt_d;
  logic [31:0]        event_count_q, event_count_d;
  logic [1:0]         event_buf_q, event_buf_d;
  logic [1:0]         clear_buffer_q, clear_buffer_d;
  logic               timeout_q, timeout_d;
  logic               req_err_q, req_err_d;

  logic [NUM_BUF-1:0] req_edge;
  logic               in_service;
  logic               all_done;
  logic               found;
  logic [1:0]         grant_idx;
  logic [1:0]         scan_idx;

  assign req_edge   = digitize_req_i & ~req_q;
  assign in_service = (state_q == StAssert) || (state_q == StWaitDone) || (state_q == StClear);
  // Masked-off LABs never report done, so treat them as finished.
  assign all_done   = &(lab_done_i | ~lab_mask_i);

  // Round-robin scan starting just after the buffer served last.
  always_comb begin
    found     = 1'b0;
    grant_idx = last_q;
    scan_idx  = last_q;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_q + 2'(i);
      if (!found && pending_q[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    sel_d          = sel_q;
    last_d         = last_q;
    dig_cnt_d      = dig_cnt_q;
    to_cnt_d       = to_cnt_q;
    event_count_d  = event_count_q;
    event_buf_d    = event_buf_q;
    clear_buffer_d = clear_buffer_q;
    timeout_d      = timeout_q;
    req_err_d      = req_err_q;
    digitize_o     = '0;
    clear_o        = 1'b0;
    event_valid_o  = 1'b0;

    case (state_q)
      StIdle: begin
        if (found) begin
          pending_d[grant_idx] = 1'b0;
          sel_d                = grant_idx;
          last_d               = grant_idx;
          dig_cnt_d            = 16'd1;
          state_d              = StAssert;
        end
      end
      StAssert: begin
        digitize_o[sel_q] = 1'b1;
        if (dig_cnt_q >= 16'(MIN_DIG_CYCLES)) begin
          to_cnt_d = '0;
          state_d  = StWaitDone;
        end else begin
          dig_cnt_d = dig_cnt_q + 16'd1;
        end
      end
      StWaitDone: begin
        digitize_o[sel_q] = 1'b1;
        if (all_done || (to_cnt_q >= 16'(TIMEOUT_CYCLES - 1))) begin
          if (!all_done) begin
            timeout_d = 1'b1;
          end
          event_count_d  = event_count_q + 32'd1;
          event_buf_d    = sel_q;
          clear_buffer_d = sel_q;
          state_d        = StClear;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      StClear: begin
        clear_o       = 1'b1;
        event_valid_o = 1'b1;
        state_d       = StGap;
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A grant above can never collide with an accepted edge: that bit was pending.
    for (int n = 0; n < NUM_BUF; n++) begin
      if (req_edge[n]) begin
        if (pending_q[n] || (in_service && (sel_q == 2'(n)))) begin
          req_err_d = 1'b1;
        end else begin
          pending_d[n] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      req_q          <= '0;
      pending_q      <= '0;
      sel_q          <= '0;
      last_q         <= 2'd3;
      dig_cnt_q      <= '0;
      to_cnt_q       <= '0;
      event_count_q  <= '0;
      event_buf_q    <= '0;
      clear_buffer_q <= '0;
      timeout_q      <= 1'b0;
      req_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= digitize_req_i;
      pending_q      <= pending_d;
      sel_q          <= sel_d;
      last_q         <= last_d;
      dig_cnt_q      <= dig_cnt_d;
      to_cnt_q       <= to_cnt_d;
      event_count_q  <= event_count_d;
      event_buf_q    <= event_buf_d;
      clear_buffer_q <= clear_buffer_d;
      timeout_q      <= timeout_d;
      req_err_q      <= req_err_d;
    end
  end

  assign clear_buffer_o = clear_buffer_q;
  assign event_count_o  = event_count_q;
  assign event_buf_o    = event_buf_q;
  assign timeout_o      = timeout_q;
  assign req_err_o      = req_err_q;
  assign busy_o         = (state_q != StIdle) || (|pending_q);

endmodule

// File: tb/tb_lab_readout_scheduler.sv
// Scoreboard bench for lab_readout_scheduler: expected readout events are queued by the
// stimulus and checked by a monitor on every clear/event pulse; timing checked directly.
module tb_lab_readout_scheduler;

  logic        clk33;
  logic        rst;
  logic [3:0]  digitize_req;
  logic [3:0]  lab_done;
  logic [3:0]  lab_mask;
  logic [3:0]  digitize;
  logic        clear;
  logic [1:0]  clear_buffer;
  logic        event_valid;
  logic [31:0] event_count;
  logic [1:0]  event_buf;
  logic        busy;
  logic        timeout;
  logic        req_err;

  lab_readout_scheduler #(
    .NUM_BUF        (4),
    .MIN_DIG_CYCLES (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk33_i        (clk33),
    .rst_i          (rst),
    .digitize_req_i (digitize_req),
    .lab_done_i     (lab_done),
    .lab_mask_i     (lab_mask),
    .digitize_o     (digitize),
    .clear_o        (clear),
    .clear_buffer_o (clear_buffer),
    .event_valid_o  (event_valid),
    .event_count_o  (event_count),
    .event_buf_o    (event_buf),
    .busy_o         (busy),
    .timeout_o      (timeout),
    .req_err_o      (req_err)
  );

  typedef struct {
    logic [1:0]  buf_idx;
    logic [31:0] count;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   dig_run    = 0;
  int   last_width = 0;

  initial clk33 = 1'b0;
  always #5 clk33 = ~clk33;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] b, input logic [31:0] c);
    exp_t e;
    e.buf_idx = b;
    e.count   = c;
    sb.push_back(e);
  endtask

  // Scoreboard monitor plus digitize-width tracker, both sampled on the falling edge.
  always @(negedge clk33) begin
    if (rst) begin
      dig_run = 0;
    end else begin
      if (|digitize) begin
        dig_run++;
      end else if (dig_run != 0) begin
        last_width = dig_run;
        dig_run    = 0;
      end
      if (clear || event_valid) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_event: got buf %0d count %0d, expected no event",
                   event_buf, event_count);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ev_clear", {31'd0, clear}, 32'd1);
          chk("ev_valid", {31'd0, event_valid}, 32'd1);
          chk("ev_clear_buffer", {30'd0, clear_buffer}, {30'd0, e.buf_idx});
          chk("ev_event_buf", {30'd0, event_buf}, {30'd0, e.buf_idx});
          chk("ev_event_count", event_count, e.count);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk33);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    digitize_req = '0;
    lab_done     = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    bit done_ok;
    done_ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (!busy) begin
        done_ok = 1'b1;
        break;
      end
    end
    if (!done_ok) begin
      compared++;
      mismatched++;
      $display("FAIL %s: got busy after %0d cycles, expected idle", name, max_cycles);
    end
  endtask

  task automatic wait_dig(input logic [3:0] pat, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (digitize == pat) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL %s: got digitize 0x%0h, expected 0x%0h", name, digitize, pat);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_digitize"}, {28'd0, digitize}, 32'd0);
    chk({tag, "_clear"}, {31'd0, clear}, 32'd0);
    chk({tag, "_clear_buffer"}, {30'd0, clear_buffer}, 32'd0);
    chk({tag, "_event_valid"}, {31'd0, event_valid}, 32'd0);
    chk({tag, "_event_count"}, event_count, 32'd0);
    chk({tag, "_event_buf"}, {30'd0, event_buf}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    chk({tag, "_req_err"}, {31'd0, req_err}, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    digitize_req = '0;
    lab_done     = '0;
    lab_mask     = 4'hF;
    do_reset();
    chk_all_zero("reset");

    // Single request on buffer 2: two-cycle grant latency, clear one cycle after done.
    tick();
    digitize_req = 4'b0100;
    tick();
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_dig_pre", {28'd0, digitize}, 32'd0);
    tick();
    chk("single_dig", {28'd0, digitize}, 32'h4);
    push(2'd2, 32'd1);
    repeat (8) tick();
    chk("single_dig_hold", {28'd0, digitize}, 32'h4);
    lab_done = 4'hF;
    tick();
    chk("single_clear", {31'd0, clear}, 32'd1);
    tick();
    chk("single_gap_clear", {31'd0, clear}, 32'd0);
    chk("single_gap_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("single_idle_busy", {31'd0, busy}, 32'd0);
    chk("single_hold_count", event_count, 32'd1);
    chk("single_hold_buf", {30'd0, event_buf}, 32'd2);
    digitize_req = '0;
    lab_done     = '0;
    tick();

    // Minimum digitize width with done already asserted.
    lab_done     = 4'hF;
    digitize_req = 4'b0001;
    push(2'd0, 32'd2);
    wait_idle(40, "minwidth_idle");
    chk("minwidth", last_width, 32'd5);

    // Simultaneous requests after reset: served 0,1,2,3.
    do_reset();
    lab_done     = 4'hF;
    digitize_req = 4'hF;
    push(2'd0, 32'd1);
    push(2'd1, 32'd2);
    push(2'd2, 32'd3);
    push(2'd3, 32'd4);
    wait_idle(100, "simul_idle");
    chk("simul_count", event_count, 32'd4);
    chk("simul_buf", {30'd0, event_buf}, 32'd3);
    digitize_req = '0;
    lab_done     = '0;
    tick();

    // Round robin: serve 1, queue 0 and 2 during its wait; expect 2 then 0.
    digitize_req = 4'b0010;
    push(2'd1, 32'd5);
    wait_dig(4'b0010, "rr_dig1");
    repeat (4) tick();
    digitize_req = 4'b0111;
    lab_done     = 4'hF;
    push(2'd2, 32'd6);
    push(2'd0, 32'd7);
    wait_idle(60, "rr_idle");
    chk("rr_no_err", {31'd0, req_err}, 32'd0);
    digitize_req = '0;
    lab_done     = '0;
    tick();

    // Duplicate edge on pending buffer 1 flags an error and is dropped.
    digitize_req = 4'b0001;
    tick();
    tick();
    digitize_req = 4'b0011;
    tick();
    digitize_req = 4'b0001;
    tick();
    digitize_req = 4'b0011;
    tick();
    chk("dup_req_err", {31'd0, req_err}, 32'd1);
    lab_done = 4'hF;
    push(2'd0, 32'd8);
    push(2'd1, 32'd9);
    wait_idle(60, "dup_idle");
    chk("dup_count", event_count, 32'd9);
    digitize_req = '0;
    lab_done     = '0;
    tick();

    // Timeout: LAB never finishes; 4 assert + 16 wait cycles then forced clear.
    chk("pre_timeout", {31'd0, timeout}, 32'd0);
    digitize_req = 4'b1000;
    push(2'd3, 32'd10);
    wait_idle(80, "to_idle");
    chk("to_width", last_width, 32'd20);
    chk("to_flag", {31'd0, timeout}, 32'd1);
    repeat (3) tick();
    chk("to_sticky", {31'd0, timeout}, 32'd1);
    digitize_req = '0;
    tick();

    // All LABs masked: wait phase lasts a single cycle.
    lab_mask     = 4'h0;
    digitize_req = 4'b0001;
    push(2'd0, 32'd11);
    wait_idle(40, "mask_idle");
    chk("mask_width", last_width, 32'd5);
    lab_mask     = 4'hF;
    digitize_req = '0;
    tick();

    // Reset during wait aborts with no clear pulse.
    digitize_req = 4'b0010;
    wait_dig(4'b0010, "abort_dig");
    repeat (4) tick();
    chk("abort_in_wait", {28'd0, digitize}, 32'h2);
    rst          = 1'b1;
    digitize_req = '0;
    tick();
    chk_all_zero("abort");
    rst = 1'b0;
    repeat (3) tick();
    chk("abort_count", event_count, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);

    chk("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
